sr_latch: RTL and testbench
===========================

Name: sr_latch

Overview:
- Clocked, synchronous-reset set/reset storage bank. Each of WIDTH bits is set by S and cleared by R, with a defined policy for the forbidden S=R=1 case.
- Provides true and complementary outputs plus invalid-input detection flags.
- Used as a control/status flag register wherever set/clear events come from independent sources.

Parameters:
- WIDTH, 1, number of independent SR cells.
- INVALID_MODE, 0, per-bit action on S=R=1: 0 = hold, 1 = set-dominant, 2 = reset-dominant. Values 3 and above behave as 0.
- RESET_VALUE, 0 (WIDTH bits), value loaded into Q on reset.

Ports:
- clk  input  1  rising-edge clock; all state changes on this edge.
- rst  input  1  synchronous, active-high reset.
- S  input  WIDTH  per-bit set request.
- R  input  WIDTH  per-bit reset request.
- err_clr  input  1  clears invalid_sticky; synchronous.
- Q  output  WIDTH  stored state (registered).
- Qbar  output  WIDTH  bitwise complement of Q, always exactly ~Q.
- invalid  output  WIDTH  per-bit registered flag: S=R=1 was sampled on the previous edge.
- invalid_sticky  output  1  set when any bit samples S=R=1; held until err_clr or rst.

Behaviour:
- Synchronous reset, active-high:
  - When rst=1 at a rising clk edge: Q=RESET_VALUE, Qbar=~RESET_VALUE, invalid=0, invalid_sticky=0.
  - rst overrides S, R and err_clr.
  - Reset asserted mid-operation takes effect at the next edge. There is no asynchronous path.
- Per-bit next state at each rising edge with rst=0:
  - S=0, R=0: hold Q.
  - S=1, R=0: Q=1.
  - S=0, R=1: Q=0.
  - S=1, R=1: resolved by INVALID_MODE (hold, force 1, or force 0).
- Latency: one cycle. S/R sampled at edge N are reflected on Q/Qbar after edge N. No combinational path from inputs to outputs.
- Qbar is derived from Q, never stored separately. Q and Qbar are never equal, including in the invalid case and after reset.
- invalid[i]:
  - After each edge with rst=0, equals S[i]&R[i] as sampled at that edge.
  - Pulses for exactly the cycles in which invalid input was sampled.
  - Asserted regardless of INVALID_MODE.
- invalid_sticky:
  - Next value = (invalid_sticky | any(S&R)) & ~err_clr, with one exception below.
  - If err_clr and a new S=R=1 occur in the same cycle, the set wins and the flag remains 1.
- Bits are fully independent; there is no cross-bit interaction except the OR into invalid_sticky.
- Inputs must be synchronous to clk. No internal synchronizers.
- X on S/R after reset is not supported. The bench drives known values.

Test Plan:
- Reset and hold: rst=1 for one edge, then S=0, R=0 for 2 cycles -> Q=0, Qbar=1, invalid=0, invalid_sticky=0 throughout.
- Set: S=1, R=0 for one edge -> Q=1, Qbar=0 after that edge. Then S=0, R=0 -> Q stays 1.
- Reset request: from Q=1, S=0, R=1 for one edge -> Q=0, Qbar=1. Then S=0, R=0 -> Q stays 0.
- Invalid input, INVALID_MODE=0:
  - From Q=0, S=1, R=1 -> Q=0, Qbar=1, invalid=1 for one cycle, invalid_sticky=1.
  - Then S=0, R=0 -> invalid=0, invalid_sticky stays 1.
  - err_clr=1 -> invalid_sticky=0 next cycle.
- Modes 1 and 2 with WIDTH=4, from Q=4'b0000:
  - Mode 1: S=4'b1010, R=4'b1100 -> Q=4'b1010, invalid=4'b1000.
  - Mode 2: same stimulus -> Q=4'b0010, invalid=4'b1000.
- Reset priority and err_clr race:
  - With Q=1 and invalid_sticky=1, assert rst=1 with S=1, R=1, err_clr=0 -> Q=0, Qbar=1, invalid=0, invalid_sticky=0.
  - Separately, err_clr=1 with S=R=1 in the same cycle -> invalid_sticky stays 1.

Source files
------------

// File: rtl/sr_latch.sv
// Bank of WIDTH clocked set/reset flag cells with a configurable S=R=1 policy.
// Also provides a per-bit invalid-input pulse and a sticky "any invalid" flag.
module sr_latch #(
    parameter int               WIDTH        = 1,
    parameter int               INVALID_MODE = 0,
    parameter logic [WIDTH-1:0] RESET_VALUE  = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] S,
    input  logic [WIDTH-1:0] R,
    input  logic             err_clr,
    output logic [WIDTH-1:0] Q,
    output logic [WIDTH-1:0] Qbar,
    output logic [WIDTH-1:0] invalid,
    output logic             invalid_sticky
);

    logic [WIDTH-1:0] r_q;
    logic [WIDTH-1:0] r_invalid;
    logic             r_sticky;
    logic [WIDTH-1:0] w_q_next;
    logic [WIDTH-1:0] w_both;
    logic             w_sticky_next;

    assign w_both = S & R;

    genvar gi;
    generate
        for (gi = 0; gi < WIDTH; gi = gi + 1) begin : g_cell
            always_comb begin
                w_q_next[gi] = r_q[gi];
                case ({S[gi], R[gi]})
                    2'b10:   w_q_next[gi] = 1'b1;
                    2'b01:   w_q_next[gi] = 1'b0;
                    2'b11: begin
                        // Unlisted mode values fall back to hold.
                        if (INVALID_MODE == 1)
                            w_q_next[gi] = 1'b1;
                        else if (INVALID_MODE == 2)
                            w_q_next[gi] = 1'b0;
                        else
                            w_q_next[gi] = r_q[gi];
                    end
                    default: w_q_next[gi] = r_q[gi];
                endcase
            end
        end
    endgenerate

    // A fresh invalid sample outranks err_clr in the same cycle.
    assign w_sticky_next = (r_sticky & ~err_clr) | (|w_both);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_q       <= RESET_VALUE;
            r_invalid <= '0;
            r_sticky  <= 1'b0;
        end else begin
            r_q       <= w_q_next;
            r_invalid <= w_both;
            r_sticky  <= w_sticky_next;
        end
    end

    assign Q              = r_q;
    assign Qbar           = ~r_q;
    assign invalid        = r_invalid;
    assign invalid_sticky = r_sticky;

endmodule

// File: tb/tb_sr_latch.sv
// Scoreboard bench: three 4-bit banks (hold / set-dominant / reset-dominant)
// share one directed stimulus stream; a monitor checks each cycle's outputs.
module tb_sr_latch;

    localparam int W = 4;

    typedef struct {
        logic [W-1:0] q0;
        logic [W-1:0] q1;
        logic [W-1:0] q2;
        logic [W-1:0] inv;
        logic         st;
        int           id;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic [W-1:0] s   = '0;
    logic [W-1:0] r   = '0;
    logic         err_clr = 1'b0;

    logic [W-1:0] q0, qb0, inv0;
    logic [W-1:0] q1, qb1, inv1;
    logic [W-1:0] q2, qb2, inv2;
    logic         st0, st1, st2;

    int n_checks = 0;
    int n_fail   = 0;
    int n_vec    = 0;
    exp_t sb_q[$];

    always #5 clk = ~clk;

    sr_latch #(.WIDTH(W), .INVALID_MODE(0), .RESET_VALUE(4'b0000)) u_m0 (
        .clk(clk), .rst(rst), .S(s), .R(r), .err_clr(err_clr),
        .Q(q0), .Qbar(qb0), .invalid(inv0), .invalid_sticky(st0));
    sr_latch #(.WIDTH(W), .INVALID_MODE(1), .RESET_VALUE(4'b0000)) u_m1 (
        .clk(clk), .rst(rst), .S(s), .R(r), .err_clr(err_clr),
        .Q(q1), .Qbar(qb1), .invalid(inv1), .invalid_sticky(st1));
    sr_latch #(.WIDTH(W), .INVALID_MODE(2), .RESET_VALUE(4'b0000)) u_m2 (
        .clk(clk), .rst(rst), .S(s), .R(r), .err_clr(err_clr),
        .Q(q2), .Qbar(qb2), .invalid(inv2), .invalid_sticky(st2));

    task automatic chk(input string name, input int id, input logic [W-1:0] act, input logic [W-1:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL vec%0d %s: got %b, expected %b", id, name, act, req);
        end
    endtask

    // Drive one vector on the falling edge and queue what must appear after the next rising edge.
    task automatic apply(input logic i_rst, input logic [W-1:0] i_s, input logic [W-1:0] i_r,
                         input logic i_ec, input logic [W-1:0] e_q0, input logic [W-1:0] e_q1,
                         input logic [W-1:0] e_q2, input logic [W-1:0] e_inv, input logic e_st);
        exp_t e;
        @(negedge clk);
        rst = i_rst; s = i_s; r = i_r; err_clr = i_ec;
        e.q0 = e_q0; e.q1 = e_q1; e.q2 = e_q2; e.inv = e_inv; e.st = e_st; e.id = n_vec;
        sb_q.push_back(e);
        $display("vec%0d: rst=%b S=%b R=%b err_clr=%b -> Q0=%b Q1=%b Q2=%b inv=%b sticky=%b",
                 n_vec, i_rst, i_s, i_r, i_ec, e_q0, e_q1, e_q2, e_inv, e_st);
        n_vec++;
    endtask

    // Monitor: outputs are valid every cycle once a vector has been issued.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (sb_q.size() != 0) begin
                e = sb_q.pop_front();
                chk("Q mode0", e.id, q0, e.q0);
                chk("Q mode1", e.id, q1, e.q1);
                chk("Q mode2", e.id, q2, e.q2);
                chk("Qbar mode0", e.id, qb0, ~e.q0);
                chk("Qbar mode1", e.id, qb1, ~e.q1);
                chk("Qbar mode2", e.id, qb2, ~e.q2);
                chk("invalid mode0", e.id, inv0, e.inv);
                chk("invalid mode1", e.id, inv1, e.inv);
                chk("invalid mode2", e.id, inv2, e.inv);
                chk("sticky mode0", e.id, {3'b000, st0}, {3'b000, e.st});
                chk("sticky mode1", e.id, {3'b000, st1}, {3'b000, e.st});
                chk("sticky mode2", e.id, {3'b000, st2}, {3'b000, e.st});
            end
        end
    end

    initial begin
        //     rst  S        R        ec    Q mode0  Q mode1  Q mode2  invalid  sticky
        apply(1'b1, 4'b0000, 4'b0000, 1'b0, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 1'b0);
        apply(1'b0, 4'b0000, 4'b0000, 1'b0, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 1'b0);
        apply(1'b0, 4'b0000, 4'b0000, 1'b0, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 1'b0);
        apply(1'b0, 4'b0001, 4'b0000, 1'b0, 4'b0001, 4'b0001, 4'b0001, 4'b0000, 1'b0);
        apply(1'b0, 4'b0000, 4'b0000, 1'b0, 4'b0001, 4'b0001, 4'b0001, 4'b0000, 1'b0);
        apply(1'b0, 4'b0000, 4'b0001, 1'b0, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 1'b0);
        apply(1'b0, 4'b0000, 4'b0000, 1'b0, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 1'b0);
        apply(1'b0, 4'b0001, 4'b0001, 1'b0, 4'b0000, 4'b0001, 4'b0000, 4'b0001, 1'b1);
        apply(1'b0, 4'b0000, 4'b0000, 1'b0, 4'b0000, 4'b0001, 4'b0000, 4'b0000, 1'b1);
        apply(1'b0, 4'b0000, 4'b0000, 1'b1, 4'b0000, 4'b0001, 4'b0000, 4'b0000, 1'b0);
        apply(1'b1, 4'b0000, 4'b0000, 1'b0, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 1'b0);
        apply(1'b0, 4'b1010, 4'b1100, 1'b0, 4'b0010, 4'b1010, 4'b0010, 4'b1000, 1'b1);
        apply(1'b0, 4'b1001, 4'b0000, 1'b0, 4'b1011, 4'b1011, 4'b1011, 4'b0000, 1'b1);
        apply(1'b1, 4'b1111, 4'b1111, 1'b0, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 1'b0);
        apply(1'b0, 4'b0001, 4'b0000, 1'b0, 4'b0001, 4'b0001, 4'b0001, 4'b0000, 1'b0);
        apply(1'b0, 4'b0100, 4'b0100, 1'b1, 4'b0001, 4'b0101, 4'b0001, 4'b0100, 1'b1);
        apply(1'b0, 4'b0000, 4'b0000, 1'b1, 4'b0001, 4'b0101, 4'b0001, 4'b0000, 1'b0);
        apply(1'b0, 4'b1111, 4'b0000, 1'b0, 4'b1111, 4'b1111, 4'b1111, 4'b0000, 1'b0);
        apply(1'b0, 4'b0000, 4'b1111, 1'b0, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 1'b0);
        @(negedge clk);
        s = '0; r = '0; err_clr = 1'b0;
        repeat (3) @(negedge clk);
        n_checks++;
        if (sb_q.size() != 0) begin
            n_fail++;
            $display("FAIL drain: %0d expectations left unchecked, expected 0", sb_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
